// File: rtl/elevator_controller_if.sv
// Panel signals between the car controller and the button/LED board.
// No latency: plain wires.
// No backpressure: level buttons in, LEDs out.
interface elevator_controller_if;
  logic st_floor_button;
  logic nd_floor_button;
  logic rd_floor_button;
  logic sos_button;
  logic weight_sensor;
  logic st_floor_led;
  logic nd_floor_led;
  logic rd_floor_led;
  logic door_status_led;
  logic weight_led;
  logic sos_led;
  logic emergency_led;

  // Controller side: reads buttons and sensors, drives LEDs.
  modport slave (
    input  st_floor_button, nd_floor_button, rd_floor_button, sos_button, weight_sensor,
    output st_floor_led, nd_floor_led, rd_floor_led, door_status_led, weight_led,
           sos_led, emergency_led
  );

  // Panel side: drives buttons and sensors, reads LEDs.
  modport master (
    output st_floor_button, nd_floor_button, rd_floor_button, sos_button, weight_sensor,
    input  st_floor_led, nd_floor_led, rd_floor_led, door_status_led, weight_led,
           sos_led, emergency_led
  );
endinterface

// File: rtl/elevator_controller.sv
// Three-floor car sequencer: call latching, collective direction-preserving travel, door timing, SOS.
// Latency: door opens 1 + N*TRAVEL_TICKS edges after a call N floors away; LEDs are registered-state decodes.
// No backpressure: buttons are sampled every cycle; overweight holds the door open indefinitely.
module elevator_controller #(
  parameter int TRAVEL_TICKS = 3,
  parameter int DOOR_TICKS   = 4
) (
  input  logic              clk,
  input  logic              rst,
  elevator_controller_if.slave io
);

  localparam int MAX_TICKS = (TRAVEL_TICKS > DOOR_TICKS) ? TRAVEL_TICKS : DOOR_TICKS;
  localparam int CW        = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;
  localparam logic [CW-1:0] TRAVEL_LD = CW'(TRAVEL_TICKS - 1);
  localparam logic [CW-1:0] DOOR_LD   = CW'(DOOR_TICKS - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    MOVE_UP   = 3'd1,
    MOVE_DOWN = 3'd2,
    DOOR_OPEN = 3'd3,
    EMERGENCY = 3'd4
  } state_t;

  state_t        state, state_d;
  logic [1:0]    floor, floor_d;
  logic [2:0]    req, req_d;
  logic          dir, dir_d;
  logic [CW-1:0] cnt, cnt_d;
  logic          sos_q;

  logic [2:0]    btn, here, req_in, nf_hot;
  logic [1:0]    nf;
  logic          sos_edge, restart, any_above, any_below, ahead, behind;

  function automatic logic [2:0] above_mask(input logic [1:0] f);
    case (f)
      2'd0:    above_mask = 3'b110;
      2'd1:    above_mask = 3'b100;
      default: above_mask = 3'b000;
    endcase
  endfunction

  function automatic logic [2:0] below_mask(input logic [1:0] f);
    case (f)
      2'd0:    below_mask = 3'b000;
      2'd1:    below_mask = 3'b001;
      default: below_mask = 3'b011;
    endcase
  endfunction

  // State register plus SOS edge-detect flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      floor <= 2'd0;
      req   <= 3'b000;
      dir   <= 1'b1;
      cnt   <= '0;
      sos_q <= 1'b0;
    end else begin
      state <= state_d;
      floor <= floor_d;
      req   <= req_d;
      dir   <= dir_d;
      cnt   <= cnt_d;
      sos_q <= io.sos_button;
    end
  end

  // Next-state logic: SOS edge overrides timing, timing/arrival overrides new calls.
  always_comb begin
    state_d = state;
    floor_d = floor;
    req_d   = req;
    dir_d   = dir;
    cnt_d   = cnt;
    nf      = floor;
    nf_hot  = 3'b000;

    btn      = {io.rd_floor_button, io.nd_floor_button, io.st_floor_button};
    here     = 3'b001 << floor;
    sos_edge = io.sos_button & ~sos_q;
    // With the door open, a call for this floor only extends the door time.
    restart  = (state == DOOR_OPEN) && (|(btn & here));
    req_in   = req | (btn & ~((state == DOOR_OPEN) ? here : 3'b000));
    any_above = |(req_in & above_mask(floor));
    any_below = |(req_in & below_mask(floor));
    ahead     = dir ? any_above : any_below;
    behind    = dir ? any_below : any_above;

    if (sos_edge) begin
      if (state == EMERGENCY) begin
        state_d = IDLE;
      end else begin
        state_d = EMERGENCY;
        req_d   = 3'b000;
        cnt_d   = '0;
      end
    end else begin
      case (state)
        IDLE: begin
          req_d = req_in;
          if (|(req_in & here)) begin
            req_d   = req_in & ~here;
            state_d = DOOR_OPEN;
            cnt_d   = DOOR_LD;
          end else if (any_above) begin
            state_d = MOVE_UP;
            dir_d   = 1'b1;
            cnt_d   = TRAVEL_LD;
          end else if (any_below) begin
            state_d = MOVE_DOWN;
            dir_d   = 1'b0;
            cnt_d   = TRAVEL_LD;
          end
        end
        MOVE_UP, MOVE_DOWN: begin
          req_d = req_in;
          if (cnt != '0) begin
            cnt_d = cnt - CW'(1);
          end else if ((state == MOVE_UP && floor == 2'd2) ||
                       (state == MOVE_DOWN && floor == 2'd0)) begin
            // Nothing beyond the shaft end; park rather than overrun.
            state_d = IDLE;
          end else begin
            nf      = (state == MOVE_UP) ? floor + 2'd1 : floor - 2'd1;
            nf_hot  = 3'b001 << nf;
            floor_d = nf;
            if (|(req_in & nf_hot)) begin
              req_d   = req_in & ~nf_hot;
              state_d = DOOR_OPEN;
              cnt_d   = DOOR_LD;
            end else begin
              cnt_d = TRAVEL_LD;
            end
          end
        end
        DOOR_OPEN: begin
          req_d = req_in;
          if (restart) begin
            cnt_d = DOOR_LD;
          end else if (cnt != '0) begin
            cnt_d = cnt - CW'(1);
          end else if (io.weight_sensor) begin
            cnt_d = '0;
          end else if (ahead) begin
            state_d = dir ? MOVE_UP : MOVE_DOWN;
            cnt_d   = TRAVEL_LD;
          end else if (behind) begin
            dir_d   = ~dir;
            state_d = dir ? MOVE_DOWN : MOVE_UP;
            cnt_d   = TRAVEL_LD;
          end else begin
            state_d = IDLE;
          end
        end
        EMERGENCY: begin
          // Calls are ignored until SOS is toggled off.
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Panel LEDs decoded from registered state.
  assign io.st_floor_led    = (floor == 2'd0);
  assign io.nd_floor_led    = (floor == 2'd1);
  assign io.rd_floor_led    = (floor == 2'd2);
  assign io.door_status_led = (state == DOOR_OPEN);
  assign io.weight_led      = (state == DOOR_OPEN) && (cnt == '0) && io.weight_sensor;
  assign io.sos_led         = (state == EMERGENCY);
  assign io.emergency_led   = (state == EMERGENCY);

endmodule
